// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM lane serializer/deserializer pair.
// Both link directions use this package.
package tdm_pkg;

    localparam int LANES_DEF = 4;
    localparam int SEL_W_DEF = $clog2(LANES_DEF);

    typedef enum logic [0:0] {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    typedef logic [SEL_W_DEF-1:0] slot_t;

endpackage

// File: rtl/tdm_demux4.sv
// Receive-side TDM demultiplexer: tracks slot position from frame_sync,
// reassembles LANES serial bits into a word and offers it over valid/ready.
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int  LANES = LANES_DEF,
    localparam int SEL_W = $clog2(LANES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [LANES-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             locked,
    output logic             sync_err,
    output logic             overrun,
    input  logic             clr_overrun
);

    state_t             state_r, state_s;
    logic [SEL_W-1:0]   slot_r, slot_s;
    logic [LANES-1:0]   acc_r, acc_s;
    logic [LANES-1:0]   dout_r, dout_s;
    logic               dout_valid_r, dout_valid_s;
    logic               locked_r;
    logic               sync_err_r, sync_err_s;
    logic               overrun_r, overrun_s;
    logic               complete_s;
    logic               drop_s;
    logic [LANES-1:0]   word_s;

    // Slot tracking, lane accumulation and frame completion detection.
    always_comb begin
        state_s    = state_r;
        slot_s     = slot_r;
        acc_s      = acc_r;
        complete_s = 1'b0;
        sync_err_s = 1'b0;
        word_s     = {din, acc_r[LANES-2:0]};
        if (din_valid) begin
            case (state_r)
                ST_HUNT: begin
                    if (frame_sync) begin
                        acc_s    = '0;
                        acc_s[0] = din;
                        slot_s   = SEL_W'(1);
                        state_s  = ST_LOCKED;
                    end else begin
                        state_s = ST_HUNT;
                    end
                end
                ST_LOCKED: begin
                    // A sync mid-frame restarts the frame at slot 0 with this beat.
                    if (frame_sync && (slot_r != SEL_W'(0))) begin
                        sync_err_s = 1'b1;
                        acc_s      = '0;
                        acc_s[0]   = din;
                        slot_s     = SEL_W'(1);
                    end else begin
                        acc_s[slot_r] = din;
                        slot_s        = slot_r + SEL_W'(1);
                        if (slot_r == SEL_W'(LANES - 1)) begin
                            complete_s = 1'b1;
                        end else begin
                            complete_s = 1'b0;
                        end
                    end
                end
                default: begin
                    state_s = ST_HUNT;
                    slot_s  = SEL_W'(0);
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Output handshake: load on completion if the slot is free, else flag overrun.
    always_comb begin
        dout_s       = dout_r;
        dout_valid_s = dout_valid_r;
        drop_s       = 1'b0;
        if (complete_s) begin
            if (!dout_valid_r || dout_ready) begin
                dout_s       = word_s;
                dout_valid_s = 1'b1;
            end else begin
                drop_s = 1'b1;
            end
        end else if (dout_valid_r && dout_ready) begin
            dout_valid_s = 1'b0;
        end else begin
            dout_valid_s = dout_valid_r;
        end
        if (drop_s) begin
            overrun_s = 1'b1;
        end else if (clr_overrun) begin
            overrun_s = 1'b0;
        end else begin
            overrun_s = overrun_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_HUNT;
            slot_r       <= SEL_W'(0);
            acc_r        <= '0;
            dout_r       <= '0;
            dout_valid_r <= 1'b0;
            locked_r     <= 1'b0;
            sync_err_r   <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            state_r      <= state_s;
            slot_r       <= slot_s;
            acc_r        <= acc_s;
            dout_r       <= dout_s;
            dout_valid_r <= dout_valid_s;
            locked_r     <= (state_s == ST_LOCKED);
            sync_err_r   <= sync_err_s;
            overrun_r    <= overrun_s;
        end
    end

    assign dout       = dout_r;
    assign dout_valid = dout_valid_r;
    assign locked     = locked_r;
    assign sync_err   = sync_err_r;
    assign overrun    = overrun_r;

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4: directed frames from the test plan
// followed by random traffic, all checked against a slot/frame reference model.
module tb_tdm_demux4;

    localparam int L = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         din = 1'b0;
    logic         din_valid = 1'b0;
    logic         frame_sync = 1'b0;
    logic [L-1:0] dout;
    logic         dout_valid;
    logic         dout_ready = 1'b0;
    logic         locked;
    logic         sync_err;
    logic         overrun;
    logic         clr_overrun = 1'b0;

    int compared = 0;
    int mismatched = 0;

    // reference model state
    bit       m_hunt;
    int       m_pos;
    bit       m_bits [L];
    bit [3:0] m_dout;
    bit       m_dv, m_locked, m_serr, m_ovr;

    int       accepted = 0;
    bit [3:0] last_word = 4'b0000;

    tdm_demux4 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .frame_sync  (frame_sync),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .locked      (locked),
        .sync_err    (sync_err),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_hunt = 1'b1;
        m_pos = 0;
        foreach (m_bits[i]) m_bits[i] = 1'b0;
        m_dout = 4'b0000;
        m_dv = 1'b0;
        m_locked = 1'b0;
        m_serr = 1'b0;
        m_ovr = 1'b0;
    endtask

    task automatic model_clock(input bit d, input bit v, input bit fs, input bit rdy, input bit clr);
        bit       done = 1'b0;
        bit       err = 1'b0;
        bit       lost = 1'b0;
        bit [3:0] w = 4'b0000;
        if (v) begin
            if (m_hunt) begin
                if (fs) begin
                    m_hunt = 1'b0;
                    m_bits[0] = d;
                    m_pos = 1;
                end
            end else if (fs && m_pos != 0) begin
                err = 1'b1;
                m_bits[0] = d;
                m_pos = 1;
            end else begin
                m_bits[m_pos] = d;
                if (m_pos == L - 1) begin
                    done = 1'b1;
                    for (int k = 0; k < L; k++) w[k] = m_bits[k];
                end
                m_pos = (m_pos + 1) % L;
            end
        end
        if (done && (!m_dv || rdy)) begin
            m_dout = w;
            m_dv = 1'b1;
        end else if (done) begin
            lost = 1'b1;
        end else if (m_dv && rdy) begin
            m_dv = 1'b0;
        end
        m_ovr = lost ? 1'b1 : (clr ? 1'b0 : m_ovr);
        m_serr = err;
        m_locked = !m_hunt;
    endtask

    task automatic check_all();
        chk("dout", 32'(dout), 32'(m_dout));
        chk("dout_valid", 32'(dout_valid), 32'(m_dv));
        chk("locked", 32'(locked), 32'(m_locked));
        chk("sync_err", 32'(sync_err), 32'(m_serr));
        chk("overrun", 32'(overrun), 32'(m_ovr));
    endtask

    task automatic step(input bit d, input bit v, input bit fs, input bit rdy, input bit clr);
        @(negedge clk);
        din = d;
        din_valid = v;
        frame_sync = fs;
        dout_ready = rdy;
        clr_overrun = clr;
        #1;
        if (dout_valid && dout_ready) begin
            accepted++;
            last_word = dout;
        end
        @(posedge clk);
        model_clock(d, v, fs, rdy, clr);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        din_valid = 1'b0;
        frame_sync = 1'b0;
        clr_overrun = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit [3:0] pat;
        int       acc0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // frame 1,0,1,1 with sync on first beat
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("t1_dv_before", 32'(dout_valid), 32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("t1_dout", 32'(dout), 32'h0000_000d);
        chk("t1_dv", 32'(dout_valid), 32'd1);
        chk("t1_locked", 32'(locked), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // unsynced beats ignored, then synced frame 0,1,1,0
        do_reset();
        repeat (3) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("t2_hunt", 32'(locked), 32'd0);
        acc0 = accepted;
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t2_count", 32'(accepted - acc0), 32'd1);
        chk("t2_word", 32'(last_word), 32'h0000_0006);

        // backpressure and overrun
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (2) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t3_overrun", 32'(overrun), 32'd1);
        chk("t3_dout_held", 32'(dout), 32'h0000_000a);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("t3_dv_drop", 32'(dout_valid), 32'd0);
        chk("t3_ovr_clr", 32'(overrun), 32'd0);

        // misaligned sync restarts the frame
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("t4_serr", 32'(sync_err), 32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("t4_serr_pulse", 32'(sync_err), 32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("t4_no_word", 32'(dout_valid), 32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("t4_dout", 32'(dout), 32'h0000_000c);

        // idle gaps between beats
        pat = 4'b1001;
        for (int k = 0; k < L; k++) begin
            repeat ($urandom_range(3, 0)) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            step(pat[k], 1'b1, (k == 0), 1'b1, 1'b0);
        end
        chk("t5_dout", 32'(dout), 32'h0000_0009);

        // mid-frame reset, then relock
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        do_reset();
        chk("t6_dv_rst", 32'(dout_valid), 32'd0);
        chk("t6_dout_rst", 32'(dout), 32'd0);
        repeat (4) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("t6_hunt", 32'(locked), 32'd0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("t6_relock", 32'(locked), 32'd1);

        // random traffic against the model
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(1, 0)), ($urandom_range(9, 0) < 7),
                 ($urandom_range(7, 0) == 0), 1'($urandom_range(1, 0)),
                 ($urandom_range(9, 0) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
